// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter state encoding, default timing
// constants for a 50 MHz system clock, common keyboard command bytes and
// the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  // Timing at 50 MHz: 120 us inhibit, 15 ms to first device clock, 2 ms transfer.
  localparam int unsigned PS2_INHIBIT_CYCLES = 6000;
  localparam int unsigned PS2_START_TIMEOUT  = 750000;
  localparam int unsigned PS2_XFER_TIMEOUT   = 100000;

  // Host-to-keyboard command bytes.
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  // Bit counter value after the ACK falling edge; the counter never exceeds it.
  localparam logic [3:0] PS2_BIT_LAST = 4'd11;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data pins plus a
// falling-edge detector on the synchronized clock.
//   clk, reset            : system clock, asynchronous active-high reset
//   ps2_clk_in/ps2_dat_in : raw pins
//   clk_s/dat_s           : synchronized pin levels
//   clk_fall              : one cycle high after a 1->0 on clk_s
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);

  logic clk_meta;
  logic dat_meta;
  logic clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_meta <= 1'b1;
      dat_meta <= 1'b1;
      clk_s    <= 1'b1;
      dat_s    <= 1'b1;
      clk_prev <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      dat_meta <= ps2_dat_in;
      clk_s    <= clk_meta;
      dat_s    <= dat_meta;
      clk_prev <= clk_s;
    end
  end

  assign clk_fall = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Accepts one byte over valid/ready, then
// inhibits the clock, requests to send, shifts out start/data/parity/stop on
// the device's falling clock edges and checks the device ACK.
//   clk, reset               : system clock, asynchronous active-high reset
//   send_valid/send_data     : byte offered; latched when send_ready is high
//   send_ready               : high only when idle
//   busy                     : high whenever a transfer is in progress
//   done / error             : one-cycle pulse on ACK / on timeout or NACK
//   ps2_clk_in/ps2_dat_in    : raw pins
//   ps2_clk_oe/ps2_dat_oe    : 1 pulls the corresponding pin low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int unsigned XFER_TIMEOUT   = PS2_XFER_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_valid,
  input  logic [7:0] send_data,
  output logic       send_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PRE    = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

  logic clk_s;
  logic dat_s;
  logic clk_fall;

  ps2_line_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_s      (clk_s),
    .dat_s      (dat_s),
    .clk_fall   (clk_fall)
  );

  ps2_tx_state_e    state_q, state_n;
  logic [8:0]       shift_q, shift_n;   // {parity, data}, bit 0 is next on the wire
  logic [3:0]       bitcnt_q, bitcnt_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;       // inhibit length, then timeout count
  logic             clk_oe_q, clk_oe_n;
  logic             dat_oe_q, dat_oe_n;
  logic             done_q, done_n;
  logic             error_q, error_n;
  logic [3:0]       bitcnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      shift_q  <= shift_n;
      bitcnt_q <= bitcnt_n;
      cnt_q    <= cnt_n;
      clk_oe_q <= clk_oe_n;
      dat_oe_q <= dat_oe_n;
      done_q   <= done_n;
      error_q  <= error_n;
    end
  end

  assign bitcnt_inc = (bitcnt_q == PS2_BIT_LAST) ? bitcnt_q : bitcnt_q + 4'd1;

  always_comb begin
    state_n  = state_q;
    shift_n  = shift_q;
    bitcnt_n = bitcnt_q;
    cnt_n    = cnt_q;
    clk_oe_n = clk_oe_q;
    dat_oe_n = dat_oe_q;
    done_n   = 1'b0;
    error_n  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (send_valid) begin
          shift_n  = {odd_parity(send_data), send_data};
          bitcnt_n = '0;
          cnt_n    = '0;
          clk_oe_n = 1'b1;
          dat_oe_n = (INHIBIT_CYCLES <= 1);
          state_n  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b1;
          cnt_n    = '0;
          state_n  = ST_REQ;
        end else begin
          cnt_n = cnt_q + 1'b1;
          // Start bit goes on the line during the last inhibit cycle.
          if (cnt_q == INH_PRE) dat_oe_n = 1'b1;
        end
      end

      ST_REQ: begin
        cnt_n = cnt_q + 1'b1;
        if (clk_fall) begin
          dat_oe_n = ~shift_q[0];
          shift_n  = {1'b0, shift_q[8:1]};
          bitcnt_n = 4'd1;
          cnt_n    = '0;
          state_n  = ST_DATA;
        end
      end

      ST_DATA: begin
        cnt_n = cnt_q + 1'b1;
        if (clk_fall) begin
          shift_n  = {1'b0, shift_q[8:1]};
          bitcnt_n = bitcnt_inc;
          if (bitcnt_q == 4'd9) begin
            dat_oe_n = 1'b0;            // stop bit: release the line
            state_n  = ST_ACK;
          end else begin
            dat_oe_n = ~shift_q[0];
          end
        end
      end

      ST_ACK: begin
        cnt_n = cnt_q + 1'b1;
        if (clk_fall) begin
          bitcnt_n = bitcnt_inc;
          if (dat_s) begin
            error_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        cnt_n = cnt_q + 1'b1;
        if (clk_s && dat_s) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Timeouts override the per-state decision, including a same-cycle done.
    if (((state_q == ST_REQ) && !clk_fall && (cnt_q == START_LAST)) ||
        (((state_q == ST_DATA) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE)) &&
         (cnt_q == XFER_LAST))) begin
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      done_n   = 1'b0;
      error_n  = 1'b1;
      state_n  = ST_IDLE;
    end
  end

  assign send_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 20;
  localparam int unsigned STO  = 300;
  localparam int unsigned XTO  = 2000;
  localparam int unsigned LOWC = 8;
  localparam int unsigned HIGC = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_valid = 1'b0;
  logic [7:0] send_data = '0;
  logic       send_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  logic [10:0] exp_q[$];

  // Open-drain bus: either side may pull low.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .XFER_TIMEOUT(XTO)) dut (
    .clk        (clk),
    .reset      (reset),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_ready (send_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
  end

  // Expected wire frame: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic offer(input logic [7:0] d);
    @(negedge clk);
    send_valid = 1'b1;
    send_data  = d;
    exp_q.push_back(frame_of(d));
    @(negedge clk);
    send_valid = 1'b0;
  endtask

  // Device model: waits for the request-to-send, then clocks nfalls edges,
  // sampling the data line on each rising edge; ACKs on edge 11 if asked.
  task automatic dev_xfer(input int nfalls, input bit ack, output logic [10:0] frame, output bit ok);
    frame = '0;
    ok = 1'b0;
    for (int i = 0; i < int'(INH) + 50; i++) begin
      @(negedge clk);
      if (busy && ps2_dat_oe && !ps2_clk_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (5) @(negedge clk);
      frame[0] = ps2_dat_in;
      for (int k = 1; k <= nfalls; k++) begin
        dev_clk = 1'b0;
        repeat (LOWC) @(negedge clk);
        dev_clk = 1'b1;
        if (k <= 10) frame[k] = ps2_dat_in;
        if (k == 10 && ack) dev_dat = 1'b0;
        if (k == 11) dev_dat = 1'b1;
        repeat (HIGC) @(negedge clk);
      end
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_outcome(input int d0, input int e0, output bit got);
    got = 1'b0;
    for (int i = 0; i < int'(XTO) + 100; i++) begin
      if (done_cnt + err_cnt > d0 + e0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got clk_oe=%b dat_oe=%b want 0 0", ps2_clk_oe, ps2_dat_oe); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (send_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", send_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got done=%b error=%b want 0 0", done, error); end
  endtask

  task automatic test_led;
    int inh_n, d0, e0;
    logic last_dat, prev_dat, busy0, rdy0;
    logic [10:0] fr, ex;
    bit ok, got;
    d0 = done_cnt; e0 = err_cnt;
    inh_n = 0; last_dat = 1'b0; prev_dat = 1'b0; busy0 = 1'b0; rdy0 = 1'b1;
    @(negedge clk);
    send_valid = 1'b1;
    send_data  = PS2_CMD_SET_LEDS;
    exp_q.push_back(frame_of(PS2_CMD_SET_LEDS));
    for (int i = 0; i < int'(INH) + 20; i++) begin
      @(negedge clk);
      if (i == 0) begin send_valid = 1'b0; busy0 = busy; rdy0 = send_ready; end
      if (ps2_clk_oe) begin
        inh_n++;
        prev_dat = last_dat;
        last_dat = ps2_dat_oe;
      end else if (inh_n > 0) begin
        break;
      end
    end
    n_tests++; if (busy0 !== 1'b1 || rdy0 !== 1'b0) begin n_fail++; $display("FAIL accept_flags: got busy=%b ready=%b want 1 0", busy0, rdy0); end
    n_tests++; if (inh_n != int'(INH)) begin n_fail++; $display("FAIL inhibit_len: got %0d want %0d", inh_n, INH); end
    n_tests++; if (last_dat !== 1'b1 || prev_dat !== 1'b0) begin n_fail++; $display("FAIL start_lead: got last=%b prev=%b want 1 0", last_dat, prev_dat); end
    n_tests++; if (ps2_dat_oe !== 1'b1 || ps2_clk_oe !== 1'b0) begin n_fail++; $display("FAIL req_drive: got clk_oe=%b dat_oe=%b want 0 1", ps2_clk_oe, ps2_dat_oe); end
    dev_xfer(11, 1'b1, fr, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL led_req: got no request want request"); end
    ex = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
    n_tests++; if (fr !== ex) begin n_fail++; $display("FAIL led_frame: got %03h want %03h", fr, ex); end
    n_tests++; if (fr !== 11'b11_1110_1101_0) begin n_fail++; $display("FAIL led_wire: got %b want 11111011010", fr); end
    wait_outcome(d0, e0, got);
    repeat (20) @(negedge clk);
    n_tests++; if (!got || done_cnt - d0 != 1) begin n_fail++; $display("FAIL led_done: got %0d want 1", done_cnt - d0); end
    n_tests++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL led_error: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, output logic [10:0] fr);
    int d0, e0;
    logic [10:0] ex;
    bit ok, got;
    d0 = done_cnt; e0 = err_cnt;
    offer(d);
    dev_xfer(11, ack, fr, ok);
    ex = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
    n_tests++; if (!ok || fr !== ex) begin n_fail++; $display("FAIL frame_%02h: got %03h want %03h", d, fr, ex); end
    wait_outcome(d0, e0, got);
    repeat (20) @(negedge clk);
    n_tests++; if (!got || done_cnt - d0 != (ack ? 1 : 0)) begin n_fail++; $display("FAIL done_%02h: got %0d want %0d", d, done_cnt - d0, ack ? 1 : 0); end
    n_tests++; if (err_cnt - e0 != (ack ? 0 : 1)) begin n_fail++; $display("FAIL error_%02h: got %0d want %0d", d, err_cnt - e0, ack ? 0 : 1); end
  endtask

  task automatic test_parity;
    logic [10:0] fr;
    run_xfer(8'h00, 1'b1, fr);
    n_tests++; if (fr[9] !== 1'b1) begin n_fail++; $display("FAIL parity_00: got %b want 1", fr[9]); end
    run_xfer(8'h01, 1'b1, fr);
    n_tests++; if (fr[9] !== 1'b0) begin n_fail++; $display("FAIL parity_01: got %b want 0", fr[9]); end
  endtask

  task automatic test_nack;
    logic [10:0] fr;
    run_xfer(PS2_CMD_ENABLE, 1'b0, fr);
  endtask

  task automatic test_start_timeout;
    int d0, e0;
    int unsigned c0, c1;
    bit seen_req, seen_end;
    logic was_err, oe_any, rdy;
    logic [10:0] drop;
    d0 = done_cnt; e0 = err_cnt;
    c0 = 0; c1 = 0; seen_req = 1'b0; seen_end = 1'b0; was_err = 1'b0; oe_any = 1'b1; rdy = 1'b0;
    offer(PS2_CMD_RESET);
    if (exp_q.size() != 0) drop = exp_q.pop_front();
    for (int i = 0; i < int'(INH) + 50; i++) begin
      @(negedge clk);
      if (busy && ps2_dat_oe && !ps2_clk_oe) begin seen_req = 1'b1; c0 = cyc; break; end
    end
    for (int i = 0; i < int'(STO) + 50; i++) begin
      @(negedge clk);
      if (done || error) begin
        seen_end = 1'b1; c1 = cyc; was_err = error;
        oe_any = ps2_clk_oe | ps2_dat_oe; rdy = send_ready;
        break;
      end
    end
    n_tests++; if (!seen_req || !seen_end || c1 - c0 != STO) begin n_fail++; $display("FAIL start_timeout_len: got %0d want %0d", c1 - c0, STO); end
    n_tests++; if (was_err !== 1'b1) begin n_fail++; $display("FAIL start_timeout_err: got %b want 1", was_err); end
    n_tests++; if (oe_any !== 1'b0 || rdy !== 1'b1) begin n_fail++; $display("FAIL start_timeout_lines: got oe=%b ready=%b want 0 1", oe_any, rdy); end
    repeat (10) @(negedge clk);
    n_tests++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin n_fail++; $display("FAIL start_timeout_count: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    logic [10:0] fr, drop;
    bit ok;
    offer(8'h55);
    if (exp_q.size() != 0) drop = exp_q.pop_front();
    dev_xfer(4, 1'b1, fr, ok);
    n_tests++; if (!ok || fr[4:0] !== 5'b01010) begin n_fail++; $display("FAIL partial_frame: got %b want 01010", fr[4:0]); end
    n_tests++; if (ps2_dat_oe !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got dat_oe=%b busy=%b want 1 1", ps2_dat_oe, busy); end
    d0 = done_cnt; e0 = err_cnt;
    #2 reset = 1'b1;
    #1;
    n_tests++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin n_fail++; $display("FAIL async_reset_oe: got clk_oe=%b dat_oe=%b want 0 0", ps2_clk_oe, ps2_dat_oe); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (send_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset: got ready=%b busy=%b want 1 0", send_ready, busy); end
    n_tests++; if (done_cnt != d0 || err_cnt != e0) begin n_fail++; $display("FAIL reset_no_pulse: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_back_to_back;
    int d0, e0;
    logic [10:0] fr, ex;
    bit ok, got, re_busy;
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    send_valid = 1'b1;
    send_data  = PS2_CMD_ENABLE;
    exp_q.push_back(frame_of(PS2_CMD_ENABLE));
    @(negedge clk);
    send_data = PS2_CMD_RESET;
    exp_q.push_back(frame_of(PS2_CMD_RESET));
    n_tests++; if (send_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_low: got %b want 0", send_ready); end
    dev_xfer(11, 1'b1, fr, ok);
    ex = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
    n_tests++; if (!ok || fr !== ex) begin n_fail++; $display("FAIL b2b_first_frame: got %03h want %03h", fr, ex); end
    wait_outcome(d0, e0, got);
    re_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy) begin re_busy = 1'b1; break; end
    end
    send_valid = 1'b0;
    n_tests++; if (!got || !re_busy) begin n_fail++; $display("FAIL b2b_reaccept: got done=%b busy=%b want 1 1", got, re_busy); end
    dev_xfer(11, 1'b1, fr, ok);
    ex = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7ff;
    n_tests++; if (!ok || fr !== ex) begin n_fail++; $display("FAIL b2b_second_frame: got %03h want %03h", fr, ex); end
    wait_outcome(d0 + 1, e0, got);
    repeat (20) @(negedge clk);
    n_tests++; if (done_cnt - d0 != 2 || err_cnt - e0 != 0) begin n_fail++; $display("FAIL b2b_done: got done=%0d err=%0d want 2 0", done_cnt - d0, err_cnt - e0); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    n_tests++; if (both_cnt != 0) begin n_fail++; $display("FAIL done_and_error: got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_led;
    test_parity;
    test_start_timeout;
    test_nack;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
